// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Operands are registered before the ALU and results/flags registered before return.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_y,
  output logic [2:0]       rsp0_zvn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_y,
  output logic [2:0]       rsp1_zvn,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [2:0]       zvn_q, zvn_d;
  logic             owner_q, owner_d;
  logic             rr_prio_q, rr_prio_d;

  logic winner;
  logic any_valid;
  logic owner_rsp_ready;

  // Contention goes to rr_prio; a lone requester always wins.
  assign any_valid = req0_valid | req1_valid;
  assign winner    = (req0_valid & req1_valid) ? rr_prio_q : req1_valid;
  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    y_d       = y_q;
    zvn_d     = zvn_q;
    owner_d   = owner_q;
    rr_prio_d = rr_prio_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req0_ready = any_valid & ~winner;
        req1_ready = any_valid & winner;
        if (any_valid) begin
          owner_d = winner;
          op_d    = winner ? req1_op : req0_op;
          a_d     = winner ? req1_a  : req0_a;
          b_d     = winner ? req1_b  : req0_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        y_d     = alu_y;
        zvn_d   = {alu_z, alu_v, alu_n};
        state_d = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          rr_prio_d = ~owner_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      y_q       <= '0;
      zvn_q     <= '0;
      owner_q   <= 1'b0;
      rr_prio_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      y_q       <= y_d;
      zvn_q     <= zvn_d;
      owner_q   <= owner_d;
      rr_prio_q <= rr_prio_d;
    end
  end

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

  assign rsp0_valid = (state_q == RESP) & ~owner_q;
  assign rsp1_valid = (state_q == RESP) & owner_q;
  assign rsp0_y     = y_q;
  assign rsp1_y     = y_q;
  assign rsp0_zvn   = zvn_q;
  assign rsp1_zvn   = zvn_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small add/sub ALU stub on the alu_* port.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a, req0_b, rsp0_y;
  logic [2:0]       rsp0_zvn;
  logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a, req1_b, rsp1_y;
  logic [2:0]       rsp1_zvn;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [OPW-1:0]   alu_op;
  logic             alu_z, alu_v, alu_n;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y), .rsp0_zvn(rsp0_zvn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y), .rsp1_zvn(rsp1_zvn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
    .busy(busy)
  );

  // ALU stub: op 0 = add, op 1 = sub
  always_comb begin
    alu_y = (alu_op == 5'd1) ? alu_a - alu_b : alu_a + alu_b;
    alu_z = (alu_y == '0);
    alu_n = alu_y[WIDTH-1];
    if (alu_op == 5'd1)
      alu_v = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_y[WIDTH-1] != alu_a[WIDTH-1]);
    else
      alu_v = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_y[WIDTH-1] != alu_a[WIDTH-1]);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=%0h", tag, got);
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0; rsp0_ready = 0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0; rsp1_ready = 0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_rdy0", req0_ready, 0);
    check("rst_rdy1", req1_ready, 0);
    check("rst_rv0", rsp0_valid, 0);
    check("rst_rv1", rsp1_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_y", rsp0_y, 0);
    do_reset();

    // Single request: 5 + 3
    req0_valid = 1; req0_op = 5'd0; req0_a = 32'h5; req0_b = 32'h3;
    #1;
    check("t1_rdy0", req0_ready, 1);
    check("t1_rdy1", req1_ready, 0);
    tick();
    req0_valid = 0;
    check("t1_exec_busy", busy, 1);
    check("t1_exec_rdy0", req0_ready, 0);
    check("t1_alu_a", alu_a, 32'h5);
    check("t1_alu_b", alu_b, 32'h3);
    check("t1_exec_rv0", rsp0_valid, 0);
    tick();
    check("t1_rv0", rsp0_valid, 1);
    check("t1_rv1", rsp1_valid, 0);
    check("t1_y", rsp0_y, 32'h8);
    check("t1_zvn", rsp0_zvn, 3'b000);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    check("t1_idle_busy", busy, 0);
    check("t1_idle_rv0", rsp0_valid, 0);

    // Simultaneous after reset: req0 first, then req1
    do_reset();
    req0_valid = 1; req0_op = 5'd0; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1; req1_op = 5'd1; req1_a = 32'd7; req1_b = 32'd7;
    #1;
    check("t2_rdy0", req0_ready, 1);
    check("t2_rdy1", req1_ready, 0);
    tick();
    req0_valid = 0;
    tick();
    check("t2_rv0", rsp0_valid, 1);
    check("t2_y0", rsp0_y, 32'd2);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    check("t2_g1_rdy1", req1_ready, 1);
    check("t2_g1_rdy0", req0_ready, 0);
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_op = 5'd0; req0_a = 32'd10; req0_b = 32'd20;
    tick();
    check("t2_rv1", rsp1_valid, 1);
    check("t2_rv0_off", rsp0_valid, 0);
    check("t2_y1", rsp1_y, 32'd0);
    check("t2_zvn1", rsp1_zvn, 3'b100);

    // Backpressure: rsp1_ready low for 5 cycles, stray rsp0_ready ignored
    rsp0_ready = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp%0d_rv1", i), rsp1_valid, 1);
      check($sformatf("bp%0d_y1", i), {rsp1_zvn, rsp1_y}, {3'b100, 32'd0});
      check($sformatf("bp%0d_rdy0", i), req0_ready, 0);
    end
    rsp0_ready = 0;
    rsp1_ready = 1;
    tick();
    rsp1_ready = 0;
    check("bp_rel_rv1", rsp1_valid, 0);
    check("bp_rel_rdy0", req0_ready, 1);
    req0_valid = 0;
    #1;

    // Fairness: both valid, both rsp_ready high; rr_prio now favours req0
    req0_valid = 1; req0_op = 5'd0; req0_a = 32'd100; req0_b = 32'd1;
    req1_valid = 1; req1_op = 5'd0; req1_a = 32'd200; req1_b = 32'd2;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("fair%0d_busy_idle", g), busy, 0);
      check($sformatf("fair%0d_rdy", g), {req1_ready, req0_ready}, (g % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check($sformatf("fair%0d_busy_exec", g), busy, 1);
      tick();
      check($sformatf("fair%0d_rv", g), {rsp1_valid, rsp0_valid}, (g % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("fair%0d_y", g), rsp0_y, (g % 2 == 0) ? 32'd101 : 32'd202);
      tick();
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;

    // Overflow / negative flags
    do_reset();
    req0_valid = 1; req0_op = 5'd0; req0_a = 32'h7FFF_FFFF; req0_b = 32'h1;
    tick();
    req0_valid = 0;
    tick();
    check("ov_rv0", rsp0_valid, 1);
    check("ov_y", rsp0_y, 32'h8000_0000);
    check("ov_zvn", rsp0_zvn, 3'b011);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;

    // Async reset during EXEC (req1 owner, prio was 1)
    req1_valid = 1; req1_op = 5'd0; req1_a = 32'h55; req1_b = 32'h11;
    #1;
    check("ar_rdy1", req1_ready, 1);
    tick();
    req1_valid = 0;
    check("ar_exec_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_alu_a", alu_a, 0);
    check("ar_alu_b", alu_b, 0);
    check("ar_rv1", rsp1_valid, 0);
    check("ar_y", rsp1_y, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ar_post%0d_rv", i), {rsp1_valid, rsp0_valid}, 2'b00);
    end
    req0_valid = 1; req0_op = 5'd0; req0_a = 32'd2; req0_b = 32'd3;
    req1_valid = 1; req1_op = 5'd0; req1_a = 32'd4; req1_b = 32'd5;
    #1;
    check("ar_next_rdy0", req0_ready, 1);
    check("ar_next_rdy1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU (32-bit A/B, 5-bit ALUOp, outputs Y, z, v, n) between two requesters, e.g. the main datapath and an address/branch-compare unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin.
- Operands are registered before driving the ALU, and results plus flags are registered before being returned.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- OPW, 5, ALU opcode width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  arbiter accepts requester 0 operation this cycle
- req0_op  in  OPW  requester 0 ALUOp
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes result
- rsp0_y  out  WIDTH  result
- rsp0_zvn  out  3  flags {z,v,n}
- req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_y, rsp1_zvn: same as requester 0, for requester 1
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_op  out  OPW  to ALU ALUOp
- alu_y  in  WIDTH  from ALU Y
- alu_z, alu_v, alu_n  in  1  from ALU flags
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high):
  - state=IDLE; op/a/b registers=0; result/flag registers=0; owner=0; rr_prio=0 (requester 0 favoured).
  - All ready/valid outputs are 0.
  - alu_a/alu_b/alu_op are 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Winner when one valid: that requester.
  - Winner when both valid: requester rr_prio.
  - reqN_ready=1 combinationally for the winner only; the other ready stays 0.
  - No valid: reqN_ready=0 for both.
  - On handshake (valid&ready): latch op/a/b and owner=winner; next state EXEC.
- EXEC (exactly 1 cycle):
  - alu_* are driven from the operand registers throughout; alu_* always reflect the registers, never requester inputs directly.
  - At the clock edge, capture alu_y and {alu_z,alu_v,alu_n} into the result registers; next state RESP.
- RESP:
  - rsp[owner]_valid=1; the other rsp valid is 0.
  - rsp*_y/zvn present the result registers to both requesters. The payload is meaningful only with valid.
  - Hold until rsp[owner]_ready=1.
  - On that edge: rr_prio = ~owner, next state IDLE.
  - No acceptance in the same cycle; the earliest next acceptance is the following cycle.
- Latency: request accepted at edge N, rsp_valid high in cycle N+2.
- Peak throughput: 1 op per 3 cycles with rsp_ready held high.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Requester protocol rules:
  - Requesters hold valid/op/a/b stable until ready.
  - Deasserting valid in IDLE without ready is legal and cancels the request.
- reqN_ready is 0 in EXEC and RESP regardless of valid.
- Result registers and operand registers hold their values in IDLE (no clearing).
- rsp_ready asserted by the non-owner, or outside RESP, is ignored.
- Reset mid-EXEC/RESP: operation discarded, no response issued, rr_prio returns to 0.
- Flags are passed through exactly as the ALU produces them for the opcode; the arbiter does not interpret opcodes.

Test Plan:
- Single request: req0 op=5'b00000, a=32'h0000_0005, b=32'h0000_0003 accepted at cycle 1 -> rsp0_valid cycle 3, rsp0_y=32'h8, zvn=3'b000; rsp1_valid stays 0.
- Simultaneous after reset: both valid at cycle 1 (req0 a=1,b=1 op add; req1 a=7,b=7 op 5'b00001 sub) -> req0 granted first (y=2). After rsp0 handshake, req1 granted; rsp1_y=0, z=1.
- Fairness: both held valid with rsp_ready=1 for 12 cycles -> grants 0,1,0,1, one every 3 cycles, busy=1 throughout except the IDLE cycles.
- Backpressure: rsp1_ready=0 for 5 cycles in RESP -> rsp1_valid and rsp1_y held stable, req0_ready=0 throughout; releases the cycle after rsp1_ready=1.
- Overflow/negative flags: a=32'h7FFF_FFFF, b=32'h1, op add -> y=32'h8000_0000, v=1, n=1, z=0.
- Async reset during EXEC -> all outputs 0 immediately, no rsp_valid afterwards. Next simultaneous request is granted to req0.
